// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/branch decode stage.
// ALU operation codes, op-class encodings, branch bit positions, the
// decoded-op record and the base-ISA funct3 -> ALU code mapping.
package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    // ALU operation codes
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 5'b00000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 5'b00001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = 5'b00010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = 5'b00011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU   = 5'b00100;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 5'b00101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = 5'b00110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = 5'b00111;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 5'b01000;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 5'b01001;
    // M-extension codes are 2'b10 followed by funct3
    localparam logic [1:0]            ALU_M_PFX  = 2'b10;

    // Op classes from the main control unit
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_IALU   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_RALU   = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_JAL    = 3'b101;
    localparam logic [2:0] OP_JALR   = 3'b110;
    localparam logic [2:0] OP_LUI    = 3'b111;

    // Bit positions in the one-hot branch vector
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;
    localparam int BR_W    = 6;

    // Decoded op record stored in the skid buffer entries
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [BR_W-1:0]       branch;
        logic                  jump;
        logic                  illegal;
    } dec_t;

    // Base-ISA ALU mapping; SUB is only reachable from register-register ops
    function automatic logic [ALU_CTRL_W-1:0] alu_fn(
        input logic [2:0] f3,
        input logic       b5,
        input logic       is_r
    );
        logic [ALU_CTRL_W-1:0] code;
        case (f3)
            3'b000:  code = (is_r && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational ALU/branch decoder: op class and function fields in,
// ALU code, one-hot branch, jump and illegal flags out.
// Optional macro ALU_DECODE_RV32M_EN enables RV32M decode of R-ALU ops
// with funct7_b0 set; without it those encodings are illegal.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       funct7_b0,
    output dec_t       dec
);

    // Decode one op; illegal encodings fall back to ADD with no branch/jump
    always_comb begin
        dec         = '0;
        dec.ctrl    = ALU_ADD;
        case (alu_op)
            OP_LOAD, OP_STORE, OP_LUI: begin
                dec.ctrl = ALU_ADD;
            end
            OP_JAL, OP_JALR: begin
                dec.ctrl = ALU_ADD;
                dec.jump = 1'b1;
            end
            OP_IALU: begin
                dec.ctrl = alu_fn(funct3, funct7_b5, 1'b0);
            end
            OP_RALU: begin
                if (funct7_b0) begin
`ifdef ALU_DECODE_RV32M_EN
                    dec.ctrl = {ALU_M_PFX, funct3};
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    dec.ctrl = alu_fn(funct3, funct7_b5, 1'b1);
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000: begin dec.ctrl = ALU_SUB;  dec.branch[BR_BEQ]  = 1'b1; end
                    3'b001: begin dec.ctrl = ALU_SUB;  dec.branch[BR_BNE]  = 1'b1; end
                    3'b100: begin dec.ctrl = ALU_SLT;  dec.branch[BR_BLT]  = 1'b1; end
                    3'b101: begin dec.ctrl = ALU_SLT;  dec.branch[BR_BGE]  = 1'b1; end
                    3'b110: begin dec.ctrl = ALU_SLTU; dec.branch[BR_BLTU] = 1'b1; end
                    3'b111: begin dec.ctrl = ALU_SLTU; dec.branch[BR_BGEU] = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU/branch decode stage with a 2-entry valid/ready skid buffer,
// flush, sideband tag pass-through and a saturating illegal-op counter.
// Optional macro ALU_DECODE_RV32M_EN (decode only, see alu_decode_comb).
// Entry M drives the outputs; entry S catches one op while out_ready is low.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 32,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic                  funct7_b0,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [BR_W-1:0]       branch,
    output logic                  jump,
    output logic                  illegal,
    output logic [TAG_W-1:0]      out_tag,
    output logic [ERR_W-1:0]      err_cnt
);

    dec_t             in_dec_s;
    logic             accept_s;
    logic             deliver_s;

    logic             m_valid_r;
    dec_t             m_dec_r;
    logic [TAG_W-1:0] m_tag_r;
    logic             s_valid_r;
    dec_t             s_dec_r;
    logic [TAG_W-1:0] s_tag_r;
    logic [ERR_W-1:0] err_cnt_r;

    alu_decode_comb u_dec (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .funct7_b0 (funct7_b0),
        .dec       (in_dec_s)
    );

    // Ready only depends on the skid entry being free and reset being low
    assign in_ready  = ~s_valid_r & ~rst;
    assign accept_s  = in_valid & in_ready;
    assign deliver_s = m_valid_r & out_ready;

    assign out_valid = m_valid_r;
    assign alu_ctrl  = m_dec_r.ctrl;
    assign branch    = m_dec_r.branch;
    assign jump      = m_dec_r.jump;
    assign illegal   = m_dec_r.illegal;
    assign out_tag   = m_tag_r;
    assign err_cnt   = err_cnt_r;

    // Skid buffer: refill M from S first to keep FIFO order, else from input
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_dec_r   <= '0;
            m_tag_r   <= '0;
            s_valid_r <= 1'b0;
            s_dec_r   <= '0;
            s_tag_r   <= '0;
        end else if (flush) begin
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
        end else if (deliver_s || !m_valid_r) begin
            if (s_valid_r) begin
                m_valid_r <= 1'b1;
                m_dec_r   <= s_dec_r;
                m_tag_r   <= s_tag_r;
                s_valid_r <= 1'b0;
            end else if (accept_s) begin
                m_valid_r <= 1'b1;
                m_dec_r   <= in_dec_s;
                m_tag_r   <= in_tag;
            end else begin
                m_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            s_valid_r <= 1'b1;
            s_dec_r   <= in_dec_s;
            s_tag_r   <= in_tag;
        end else begin
            s_valid_r <= s_valid_r;
        end
    end

    // Count delivered illegal ops, saturating; a flush does not undo a delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (deliver_s && m_dec_r.illegal && (err_cnt_r != {ERR_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage.
// Expected values are hand-derived; RV32M expectations follow the
// ALU_DECODE_RV32M_EN macro.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        funct7_b0;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_ctrl;
    logic [5:0]  branch;
    logic        jump;
    logic        illegal;
    logic [31:0] out_tag;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;

    alu_decode_stage #(.TAG_W(32), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .funct7_b0 (funct7_b0),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .branch    (branch),
        .jump      (jump),
        .illegal   (illegal),
        .out_tag   (out_tag),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic b5,
                         input logic b0, input logic [31:0] tag);
        alu_op    = op;
        funct3    = f3;
        funct7_b5 = b5;
        funct7_b0 = b0;
        in_tag    = tag;
    endtask

    // Stream one op with out_ready high and check it on the next cycle
    task automatic vec(input string name, input logic [2:0] op, input logic [2:0] f3,
                       input logic b5, input logic b0, input logic [4:0] ectrl,
                       input logic [5:0] ebr, input logic ej, input logic eil,
                       input logic [31:0] tag);
        drive(op, f3, b5, b0, tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_ctrl"},  {27'd0, alu_ctrl},  {27'd0, ectrl});
        chk({name, "_br"},    {26'd0, branch},    {26'd0, ebr});
        chk({name, "_jump"},  {31'd0, jump},      {31'd0, ej});
        chk({name, "_ill"},   {31'd0, illegal},   {31'd0, eil});
        chk({name, "_tag"},   out_tag,            tag);
        if (eil) exp_err++;
    endtask

    int          dcount;
    logic [31:0] dtags [0:7];
    int          next_tag;
    logic        saw_stall;
    logic        acc_now;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'd0);

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready},  32'd0);
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl",     {27'd0, alu_ctrl},  32'd0);
        chk("rst_branch",   {26'd0, branch},    32'd0);
        chk("rst_jump",     {31'd0, jump},      32'd0);
        chk("rst_illegal",  {31'd0, illegal},   32'd0);
        chk("rst_tag",      out_tag,            32'd0);
        chk("rst_err",      {24'd0, err_cnt},   32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // SUB, then the unsigned branches and an illegal branch back-to-back
        vec("rsub",  3'b011, 3'b000, 1'b1, 1'b0, 5'b00001, 6'b000000, 1'b0, 1'b0, 32'h10);
        vec("bltu",  3'b100, 3'b110, 1'b0, 1'b0, 5'b00100, 6'b010000, 1'b0, 1'b0, 32'h11);
        vec("bgeu",  3'b100, 3'b111, 1'b0, 1'b0, 5'b00100, 6'b100000, 1'b0, 1'b0, 32'h12);
        vec("b010",  3'b100, 3'b010, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b1, 32'h13);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("err_one",    {24'd0, err_cnt},   32'd1);

        // Remaining decode space
        vec("iadd",  3'b001, 3'b000, 1'b1, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b0, 32'h20);
        vec("isra",  3'b001, 3'b101, 1'b1, 1'b0, 5'b00111, 6'b000000, 1'b0, 1'b0, 32'h21);
        vec("isrl",  3'b001, 3'b101, 1'b0, 1'b0, 5'b00110, 6'b000000, 1'b0, 1'b0, 32'h22);
        vec("isltu", 3'b001, 3'b011, 1'b0, 1'b0, 5'b00100, 6'b000000, 1'b0, 1'b0, 32'h23);
        vec("islt",  3'b001, 3'b010, 1'b0, 1'b0, 5'b00011, 6'b000000, 1'b0, 1'b0, 32'h24);
        vec("rsll",  3'b011, 3'b001, 1'b0, 1'b0, 5'b00010, 6'b000000, 1'b0, 1'b0, 32'h25);
        vec("rxor",  3'b011, 3'b100, 1'b0, 1'b0, 5'b00101, 6'b000000, 1'b0, 1'b0, 32'h26);
        vec("ror",   3'b011, 3'b110, 1'b0, 1'b0, 5'b01000, 6'b000000, 1'b0, 1'b0, 32'h27);
        vec("rand",  3'b011, 3'b111, 1'b0, 1'b0, 5'b01001, 6'b000000, 1'b0, 1'b0, 32'h28);
        vec("radd",  3'b011, 3'b000, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b0, 32'h29);
        vec("beq",   3'b100, 3'b000, 1'b0, 1'b0, 5'b00001, 6'b000001, 1'b0, 1'b0, 32'h2A);
        vec("bne",   3'b100, 3'b001, 1'b0, 1'b0, 5'b00001, 6'b000010, 1'b0, 1'b0, 32'h2B);
        vec("blt",   3'b100, 3'b100, 1'b0, 1'b0, 5'b00011, 6'b000100, 1'b0, 1'b0, 32'h2C);
        vec("bge",   3'b100, 3'b101, 1'b0, 1'b0, 5'b00011, 6'b001000, 1'b0, 1'b0, 32'h2D);
        vec("b011",  3'b100, 3'b011, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b1, 32'h2E);
        vec("jal",   3'b101, 3'b000, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b1, 1'b0, 32'h2F);
        vec("jalr",  3'b110, 3'b000, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b1, 1'b0, 32'h30);
        vec("load",  3'b000, 3'b010, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b0, 32'h31);
        vec("store", 3'b010, 3'b010, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b0, 32'h32);
        vec("lui",   3'b111, 3'b000, 1'b0, 1'b0, 5'b00000, 6'b000000, 1'b0, 1'b0, 32'h33);
`ifdef ALU_DECODE_RV32M_EN
        vec("mdiv",  3'b011, 3'b100, 1'b0, 1'b1, 5'b10100, 6'b000000, 1'b0, 1'b0, 32'h34);
        vec("mmul",  3'b011, 3'b000, 1'b0, 1'b1, 5'b10000, 6'b000000, 1'b0, 1'b0, 32'h35);
`else
        vec("mdiv",  3'b011, 3'b100, 1'b0, 1'b1, 5'b00000, 6'b000000, 1'b0, 1'b1, 32'h34);
        vec("mmul",  3'b011, 3'b000, 1'b0, 1'b1, 5'b00000, 6'b000000, 1'b0, 1'b1, 32'h35);
`endif
        in_valid = 1'b0;
        tick();
        chk("err_after_table", {24'd0, err_cnt}, exp_err);

        // Stream tags 1..4, out_ready low on cycles 2 and 3
        drive(3'b011, 3'b000, 1'b0, 1'b0, 32'd0);
        dcount    = 0;
        next_tag  = 1;
        saw_stall = 1'b0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c == 2 || c == 3);
            in_valid  = (next_tag <= 4);
            in_tag    = next_tag;
            #0;
            acc_now = in_valid && in_ready;
            if (next_tag <= 4 && !in_ready) saw_stall = 1'b1;
            if (c == 3) chk("stall_hold_tag", out_tag, 32'd2);
            if (out_valid && out_ready && dcount < 8) begin
                dtags[dcount] = out_tag;
                dcount++;
            end
            tick();
            if (acc_now) next_tag++;
        end
        in_valid = 1'b0;
        chk("stream_count", dcount, 32'd4);
        chk("stream_stall", {31'd0, saw_stall}, 32'd1);
        for (int i = 0; i < 4; i++) chk("stream_order", dtags[i], i + 1);

        // Flush with M and S full and a new op offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'hA1;
        tick();
        chk("fl_m_tag", out_tag, 32'hA1);
        in_tag = 32'hA2;
        tick();
        chk("fl_s_full", {31'd0, in_ready}, 32'd0);
        flush  = 1'b1;
        in_tag = 32'hA3;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        // Flush with only M full; the same-cycle accept is discarded
        in_valid = 1'b1;
        in_tag   = 32'hA4;
        tick();
        flush  = 1'b1;
        in_tag = 32'hA5;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("fl2_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b1;
        in_tag   = 32'hB0;
        tick();
        in_valid = 1'b0;
        chk("fl_after_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_after_tag",   out_tag,            32'hB0);

        // Saturate the illegal-op counter
        drive(3'b100, 3'b010, 1'b0, 1'b0, 32'hEE);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("err_sat", {24'd0, err_cnt}, 32'd255);
        for (int i = 0; i < 5; i++) tick();
        chk("err_hold", {24'd0, err_cnt}, 32'd255);

        // Reset mid-operation with both entries full
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err",   {24'd0, err_cnt},   32'd0);
        chk("mid_rst_tag",   out_tag,            32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_ready2", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mid_rst_drop", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
